// File: rtl/pic16_pkg.sv
// Shared constants for the PIC16 interrupt controller: INTCON address and bit
// positions, default vector and the interrupt sequencer state encoding.
package pic16_pkg;

  localparam logic [6:0]  A_INTCON   = 7'h0B;
  localparam logic [12:0] INT_VECTOR = 13'h0004;

  localparam int GIE  = 7;
  localparam int PEIE = 6;
  localparam int T0IE = 5;
  localparam int INTE = 4;
  localparam int RBIE = 3;
  localparam int T0IF = 2;
  localparam int INTF = 1;
  localparam int RBIF = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ISR  = 2'd2
  } pic16_state_e;

endpackage

// File: rtl/pic16_edge_sync.sv
// Multi-flop synchronizer for asynchronous pins plus a history flop that
// turns the synchronized value into single-cycle rise/fall pulses.
module pic16_edge_sync #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;
  logic [WIDTH-1:0]                  hist_q;

  // stage_q[0] samples the raw pin; the top stage is the metastability-safe copy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stage_q <= '0;
      hist_q  <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], d};
      hist_q  <= stage_q[SYNC_STAGES-1];
    end
  end

  assign sync = stage_q[SYNC_STAGES-1];
  assign rise = sync & ~hist_q;
  assign fall = ~sync & hist_q;

endmodule

// File: rtl/pic16_int_ctrl.sv
// PIC16 interrupt controller: owns INTCON, collects TMR0/INT/RB-change flags and
// sequences interrupt entry/exit with the core (IRQ -> IRQ_ACK -> RETFIE).
module pic16_int_ctrl
  import pic16_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [12:0] VECTOR      = INT_VECTOR
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        F_W,
  input  logic [8:0]  EA,
  input  logic [7:0]  WDATA,
  input  logic        RD_PORTB,
  input  logic        T0IF_SET,
  input  logic        INT_PIN,
  input  logic        INTEDG,
  input  logic [3:0]  RB_IN,
  input  logic [3:0]  TRISB_HI,
  input  logic        SLEEP,
  input  logic        IRQ_ACK,
  input  logic        RETFIE,
  output logic [7:0]  INTCON_Q,
  output logic        IRQ,
  output logic [12:0] VEC,
  output logic        WAKE
);

  // Handshake: IRQ stays high while the sequencer is in PEND. The core answers
  // with a one-cycle IRQ_ACK (honoured only in PEND) and later a one-cycle RETFIE.

  pic16_state_e state_q, state_n;
  logic [7:0]   intcon_q, intcon_n;
  logic [3:0]   rb_latch_q;
  logic         irq_d, wake_d, ack_ok, pending, gie, wr_intcon;

  logic       int_sync, int_rise, int_fall, int_evt;
  logic [3:0] rb_sync, rb_rise, rb_fall, rb_mis;
  logic       unused_ok;

  pic16_edge_sync #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES)) u_int_sync (
    .CLK(CLK), .RST(RST), .d(INT_PIN),
    .sync(int_sync), .rise(int_rise), .fall(int_fall)
  );

  pic16_edge_sync #(.WIDTH(4), .SYNC_STAGES(SYNC_STAGES)) u_rb_sync (
    .CLK(CLK), .RST(RST), .d(RB_IN),
    .sync(rb_sync), .rise(rb_rise), .fall(rb_fall)
  );

  // EA[8:7] are bank bits; INTCON is mirrored in every bank.
  assign unused_ok = &{1'b0, EA[8:7], int_sync, rb_rise, rb_fall};

  assign wr_intcon = F_W && (EA[6:0] == A_INTCON);
  assign pending   = |(intcon_q[T0IE:RBIE] & intcon_q[T0IF:RBIF]);
  assign gie       = intcon_q[GIE];
  assign int_evt   = INTEDG ? int_rise : int_fall;
  assign rb_mis    = (rb_sync ^ rb_latch_q) & TRISB_HI;

  // Hardware sets and GIE sequencing are applied after the software write so they win.
  always_comb begin
    intcon_n = intcon_q;
    if (wr_intcon)  intcon_n       = WDATA;
    if (T0IF_SET)   intcon_n[T0IF] = 1'b1;
    if (int_evt)    intcon_n[INTF] = 1'b1;
    if (|rb_mis)    intcon_n[RBIF] = 1'b1;
    if (ack_ok)     intcon_n[GIE]  = 1'b0;
    else if (RETFIE) intcon_n[GIE] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      intcon_q   <= 8'h00;
      rb_latch_q <= 4'h0;
      IRQ        <= 1'b0;
      WAKE       <= 1'b0;
    end else begin
      state_q  <= state_n;
      intcon_q <= intcon_n;
      IRQ      <= irq_d;
      WAKE     <= wake_d;
      if (RD_PORTB) rb_latch_q <= rb_sync;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (gie && pending) state_n = PEND;
      PEND: begin
        if (IRQ_ACK)                 state_n = ISR;
        else if (!(gie && pending))  state_n = IDLE;
      end
      ISR:     if (RETFIE) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ISR never requests, so a GIE set by software inside the handler cannot nest.
  always_comb begin
    ack_ok = (state_q == PEND) && IRQ_ACK;
    irq_d  = (state_n == PEND);
    wake_d = SLEEP && pending;
  end

  assign INTCON_Q = intcon_q;
  assign VEC      = VECTOR;

endmodule

// File: doc/pic16_int_ctrl.md
Name: pic16_int_ctrl

Overview:
Interrupt controller for the PIC16 core. Owns the INTCON register (file address 0x0B, mirrored at 8B/10B/18B). Collects three interrupt sources: TMR0 overflow, the RB0/INT pin edge, and the RB<7:4> change. Sequences interrupt entry and exit with the core through an IRQ/ACK/RETFIE handshake, supplies the interrupt vector, and raises WAKE to end SLEEP mode.

Parameters:
SYNC_STAGES, 2, flip-flop stages in the synchronizer for the INT pin and RB<7:4> (minimum 2).
VECTOR, 13'h0004, program address the core loads on interrupt acceptance.

Ports:
CLK  input  1  clock
RST  input  1  reset, asynchronous, active-high
F_W  input  1  core data-memory write enable
EA  input  9  core effective address {RP/IRP, f}
WDATA  input  8  core ALU result (write data)
RD_PORTB  input  1  one-cycle pulse when the core reads PORTB; reloads the RB mismatch latch
T0IF_SET  input  1  one-cycle pulse on TMR0 overflow
INT_PIN  input  1  asynchronous RB0/INT pin
INTEDG  input  1  OPTION<6>: 1 = rising edge, 0 = falling edge
RB_IN  input  4  asynchronous RB<7:4> pins
TRISB_HI  input  4  TRISB<7:4>; only input-configured bits participate
SLEEP  input  1  core sleep-mode flag
IRQ_ACK  input  1  one-cycle pulse: core pushed PC and loads VECTOR
RETFIE  input  1  one-cycle pulse: core executing RETFIE
INTCON_Q  output  8  INTCON value, for the core SDATA read mux
IRQ  output  1  registered interrupt request to the core
VEC  output  13  constant VECTOR
WAKE  output  1  registered wake request while SLEEP

Behaviour:
- INTCON bit map: 7 GIE, 6 PEIE, 5 T0IE, 4 INTE, 3 RBIE, 2 T0IF, 1 INTF, 0 RBIF. All bits are read/write. PEIE has no source attached.
- Reset values: INTCON=8'h00, IRQ=0, WAKE=0, state=IDLE, synchronizers=0, RB latch=4'h0.
- Register write: on the clock edge where F_W && EA[6:0]==7'h0B, INTCON<=WDATA.
- Same-edge conflicts:
  - A hardware flag set wins over a software write of 0 to that bit.
  - On IRQ_ACK, GIE<=0 wins over a software write.
  - On RETFIE, GIE<=1 wins over a software write.
- T0IF: set on the edge after a T0IF_SET pulse.
- INTF:
  - INT_PIN passes through SYNC_STAGES flip-flops plus one history flop.
  - The selected edge (per INTEDG) sets INTF.
  - Latency from pin to INTF = SYNC_STAGES+1 cycles.
  - A change of INTEDG itself does not generate an edge.
- RBIF:
  - RB_IN is synchronized.
  - The mismatch vector is (sync ^ latch) & TRISB_HI. Any bit set in it sets RBIF on every edge while the mismatch persists.
  - RD_PORTB loads latch<=sync. Clearing RBIF by software is effective only after the mismatch is removed.
- pending = |(INTCON[5:3] & INTCON[2:0]).
- State machine:
  - IDLE: IRQ=0. If GIE && pending, go to PEND; IRQ=1 from the next cycle.
  - PEND: IRQ=1.
    - IRQ_ACK: GIE<=0, go to ISR, IRQ=0 next cycle.
    - Otherwise, if !(GIE && pending) (software cleared it), return to IDLE, IRQ=0 next cycle.
    - IRQ_ACK wins over a simultaneous de-qualification.
  - ISR: IRQ is held 0 even if software sets GIE (no nesting). On RETFIE: GIE<=1, go to IDLE. If pending is still set, IRQ reasserts 1 cycle later, i.e. 2 edges after RETFIE.
  - IRQ_ACK outside PEND is ignored.
  - RETFIE outside ISR sets GIE only; the state is unchanged.
- Latency: flag set to IRQ high = 1 cycle.
- WAKE<=SLEEP && pending, independent of GIE. If GIE=0 the core resumes at PC+1 without vectoring.
- Mid-operation reset: asynchronously forces all reset values; an outstanding IRQ drops immediately.
- VEC is constant and never changes.

Decomposition:
- Package pic16_pkg holds:
  - A_INTCON = 7'h0B
  - INTCON bit indices (GIE..RBIF)
  - INT_VECTOR = 13'h0004
  - state encodings IDLE=2'd0, PEND=2'd1, ISR=2'd2
- One sub-module, pic16_edge_sync: a parameterised-width SYNC_STAGES synchronizer plus history flop. It outputs the synchronized value and rise/fall pulses. It is instantiated twice: width 1 for INT_PIN, width 4 for RB_IN.

Test Plan:
1. Reset, then write INTCON=8'hA0 (GIE, T0IE). Pulse T0IF_SET -> INTCON_Q=8'hA4 next edge; IRQ=1 one cycle later. Pulse IRQ_ACK -> INTCON_Q=8'h24, IRQ=0. Clear T0IF by write 8'h20, then RETFIE -> INTCON_Q=8'hA0, IRQ stays 0.
2. INTCON=8'h90, INTEDG=1. INT_PIN 0->1 -> INTF=1 exactly SYNC_STAGES+1=3 edges later, IRQ=1 on the 4th. Falling edge with INTEDG=1 -> no set.
3. INTCON=8'h88, TRISB_HI=4'hF, latch loaded 4'h0 via RD_PORTB. RB_IN=4'h2 -> RBIF=1. Write RBIF=0 without RD_PORTB -> RBIF re-sets next edge. After RD_PORTB then a clear -> stays 0. Same change with TRISB_HI=4'h0 -> no set.
4. In PEND (IRQ=1), write INTCON=8'h20 (GIE=0) with no ACK -> IRQ=0 next cycle, state IDLE. Write of 0 to T0IF on the same edge as a T0IF_SET pulse -> T0IF=1.
5. ISR entered with T0IF left set. Software sets GIE -> IRQ remains 0. RETFIE -> IRQ=1 two edges later.
6. SLEEP=1, INTCON=8'h20 (GIE=0). Pulse T0IF_SET -> WAKE=1 one cycle after T0IF, IRQ stays 0. Assert RST mid-PEND -> IRQ, WAKE, INTCON_Q=0 asynchronously.
